// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model standing in for host DRAM behind the accelerator's gmem port.
// Serves one write burst and one read burst concurrently; INCR/FIXED bursts, byte strobes, fixed read latency.
module axi_mem_responder #(
   parameter int DATA_W    = 64,
   parameter int ADDR_W    = 32,
   parameter int ID_W      = 6,
   parameter int MEM_WORDS = 4096,
   parameter int RD_LAT    = 2
) (
   input  logic                ap_clk,
   input  logic                ap_rst_n,
   input  logic                s_axi_awvalid,
   output logic                s_axi_awready,
   input  logic [ID_W-1:0]     s_axi_awid,
   input  logic [ADDR_W-1:0]   s_axi_awaddr,
   input  logic [7:0]          s_axi_awlen,
   input  logic [2:0]          s_axi_awsize,
   input  logic [1:0]          s_axi_awburst,
   input  logic                s_axi_wvalid,
   output logic                s_axi_wready,
   input  logic [DATA_W-1:0]   s_axi_wdata,
   input  logic [DATA_W/8-1:0] s_axi_wstrb,
   input  logic                s_axi_wlast,
   output logic                s_axi_bvalid,
   input  logic                s_axi_bready,
   output logic [ID_W-1:0]     s_axi_bid,
   output logic [1:0]          s_axi_bresp,
   input  logic                s_axi_arvalid,
   output logic                s_axi_arready,
   input  logic [ID_W-1:0]     s_axi_arid,
   input  logic [ADDR_W-1:0]   s_axi_araddr,
   input  logic [7:0]          s_axi_arlen,
   input  logic [2:0]          s_axi_arsize,
   input  logic [1:0]          s_axi_arburst,
   output logic                s_axi_rvalid,
   input  logic                s_axi_rready,
   output logic [ID_W-1:0]     s_axi_rid,
   output logic [DATA_W-1:0]   s_axi_rdata,
   output logic [1:0]          s_axi_rresp,
   output logic                s_axi_rlast
);
   localparam int LANES   = DATA_W / 8;
   localparam int BYTE_AW = $clog2(LANES);
   localparam int IDX_W   = $clog2(MEM_WORDS);
   localparam int LAT_W   = $clog2(RD_LAT) + 1;
   localparam logic [2:0] FULL_SIZE   = 3'(BYTE_AW);
   localparam logic [1:0] BURST_FIXED = 2'b00;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

   logic [DATA_W-1:0] mem [MEM_WORDS];

   // Holds both ready outputs low while reset is asserted and for the first edge after.
   logic rdy_q;

   w_state_e          w_state_q, w_state_d;
   logic [ID_W-1:0]   wid_q, wid_d;
   logic [IDX_W-1:0]  widx_q, widx_d;
   logic [7:0]        wlen_q, wlen_d, wbeat_q, wbeat_d;
   logic              wfixed_q, wfixed_d, werr_q, werr_d;
   logic              mem_we;

   r_state_e          r_state_q, r_state_d;
   logic [ID_W-1:0]   rid_q, rid_d;
   logic [IDX_W-1:0]  ridx_q, ridx_d;
   logic [7:0]        rlen_q, rlen_d, rbeat_q, rbeat_d;
   logic              rfixed_q, rfixed_d, rerr_q, rerr_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [IDX_W-1:0]  ar_idx, rnext_idx;
   logic              ar_err;
   logic              unused_addr_bits;

   assign ar_idx    = s_axi_araddr[BYTE_AW +: IDX_W];
   assign ar_err    = (s_axi_arsize != FULL_SIZE);
   assign rnext_idx = rfixed_q ? ridx_q : ridx_q + IDX_W'(1);
   assign unused_addr_bits = &{1'b0, s_axi_awaddr, s_axi_araddr};

   always_comb begin
      w_state_d     = w_state_q;
      wid_d         = wid_q;
      widx_d        = widx_q;
      wlen_d        = wlen_q;
      wbeat_d       = wbeat_q;
      wfixed_d      = wfixed_q;
      werr_d        = werr_q;
      mem_we        = 1'b0;
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_bvalid  = 1'b0;
      s_axi_bresp   = 2'b00;
      unique case (w_state_q)
         W_IDLE: begin
            s_axi_awready = rdy_q;
            if (rdy_q && s_axi_awvalid) begin
               wid_d     = s_axi_awid;
               widx_d    = s_axi_awaddr[BYTE_AW +: IDX_W];
               wlen_d    = s_axi_awlen;
               wfixed_d  = (s_axi_awburst == BURST_FIXED);
               werr_d    = (s_axi_awsize != FULL_SIZE);
               wbeat_d   = 8'd0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            s_axi_wready = 1'b1;
            if (s_axi_wvalid) begin
               mem_we  = !werr_q;
               if (s_axi_wlast != (wbeat_q == wlen_q)) werr_d = 1'b1;
               wbeat_d = wbeat_q + 8'd1;
               if (!wfixed_q) widx_d = widx_q + IDX_W'(1);
               if (wbeat_q == wlen_q) w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            s_axi_bvalid = 1'b1;
            s_axi_bresp  = werr_q ? 2'b10 : 2'b00;
            if (s_axi_bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Memory reads below see pre-edge contents, so same-cycle collisions return old data.
   always_comb begin
      r_state_d     = r_state_q;
      rid_d         = rid_q;
      ridx_d        = ridx_q;
      rlen_d        = rlen_q;
      rbeat_d       = rbeat_q;
      rfixed_d      = rfixed_q;
      rerr_d        = rerr_q;
      lat_d         = lat_q;
      rdata_d       = rdata_q;
      s_axi_arready = 1'b0;
      s_axi_rvalid  = 1'b0;
      s_axi_rlast   = 1'b0;
      s_axi_rresp   = 2'b00;
      unique case (r_state_q)
         R_IDLE: begin
            s_axi_arready = rdy_q;
            if (rdy_q && s_axi_arvalid) begin
               rid_d    = s_axi_arid;
               ridx_d   = ar_idx;
               rlen_d   = s_axi_arlen;
               rfixed_d = (s_axi_arburst == BURST_FIXED);
               rerr_d   = ar_err;
               rbeat_d  = 8'd0;
               lat_d    = LAT_W'(RD_LAT - 1);
               if (RD_LAT == 1) begin
                  rdata_d   = ar_err ? '0 : mem[ar_idx];
                  r_state_d = R_DATA;
               end else begin
                  r_state_d = R_WAIT;
               end
            end
         end
         R_WAIT: begin
            lat_d = lat_q - LAT_W'(1);
            if (lat_q == LAT_W'(1)) begin
               rdata_d   = rerr_q ? '0 : mem[ridx_q];
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            s_axi_rvalid = 1'b1;
            s_axi_rlast  = (rbeat_q == rlen_q);
            s_axi_rresp  = rerr_q ? 2'b10 : 2'b00;
            if (s_axi_rready) begin
               if (rbeat_q == rlen_q) begin
                  r_state_d = R_IDLE;
               end else begin
                  rbeat_d = rbeat_q + 8'd1;
                  ridx_d  = rnext_idx;
                  rdata_d = rerr_q ? '0 : mem[rnext_idx];
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rdy_q     <= 1'b0;
         w_state_q <= W_IDLE;
         wid_q     <= '0;
         widx_q    <= '0;
         wlen_q    <= '0;
         wbeat_q   <= '0;
         wfixed_q  <= 1'b0;
         werr_q    <= 1'b0;
         r_state_q <= R_IDLE;
         rid_q     <= '0;
         ridx_q    <= '0;
         rlen_q    <= '0;
         rbeat_q   <= '0;
         rfixed_q  <= 1'b0;
         rerr_q    <= 1'b0;
         lat_q     <= '0;
         rdata_q   <= '0;
      end else begin
         rdy_q     <= 1'b1;
         w_state_q <= w_state_d;
         wid_q     <= wid_d;
         widx_q    <= widx_d;
         wlen_q    <= wlen_d;
         wbeat_q   <= wbeat_d;
         wfixed_q  <= wfixed_d;
         werr_q    <= werr_d;
         r_state_q <= r_state_d;
         rid_q     <= rid_d;
         ridx_q    <= ridx_d;
         rlen_q    <= rlen_d;
         rbeat_q   <= rbeat_d;
         rfixed_q  <= rfixed_d;
         rerr_q    <= rerr_d;
         lat_q     <= lat_d;
         rdata_q   <= rdata_d;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (mem_we) begin
         for (int b = 0; b < LANES; b++) begin
            if (s_axi_wstrb[b]) mem[widx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
         end
      end
   end

   assign s_axi_bid   = wid_q;
   assign s_axi_rid   = rid_q;
   assign s_axi_rdata = rdata_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: bursts, strobes, backpressure, error responses, aliasing, reset.
module tb_axi_mem_responder;
   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b1;
   logic        s_axi_awvalid = 1'b0, s_axi_awready;
   logic [5:0]  s_axi_awid = '0;
   logic [31:0] s_axi_awaddr = '0;
   logic [7:0]  s_axi_awlen = '0;
   logic [2:0]  s_axi_awsize = '0;
   logic [1:0]  s_axi_awburst = '0;
   logic        s_axi_wvalid = 1'b0, s_axi_wready;
   logic [63:0] s_axi_wdata = '0;
   logic [7:0]  s_axi_wstrb = '0;
   logic        s_axi_wlast = 1'b0;
   logic        s_axi_bvalid, s_axi_bready = 1'b0;
   logic [5:0]  s_axi_bid;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_arvalid = 1'b0, s_axi_arready;
   logic [5:0]  s_axi_arid = '0;
   logic [31:0] s_axi_araddr = '0;
   logic [7:0]  s_axi_arlen = '0;
   logic [2:0]  s_axi_arsize = '0;
   logic [1:0]  s_axi_arburst = '0;
   logic        s_axi_rvalid, s_axi_rready = 1'b0;
   logic [5:0]  s_axi_rid;
   logic [63:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rlast;

   axi_mem_responder #(.DATA_W(64), .ADDR_W(32), .ID_W(6), .MEM_WORDS(4096), .RD_LAT(2)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awid(s_axi_awid),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
      .s_axi_awburst(s_axi_awburst), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bid(s_axi_bid),
      .s_axi_bresp(s_axi_bresp), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
      .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_rvalid(s_axi_rvalid),
      .s_axi_rready(s_axi_rready), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
      .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast)
   );

   always #5 ap_clk = ~ap_clk;

   int checks = 0;
   int errors = 0;

   logic [63:0] wd [16];
   logic [7:0]  ws [16];
   logic [63:0] rd [16];
   logic        rl [16];
   logic [1:0]  rr, bresp_s;
   logic [5:0]  ri, bid_s;
   int          nbeat, lat, stall_bad, extra, bwait;

   task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [5:0] id, input int last_at);
      int n;
      @(negedge ap_clk);
      s_axi_awvalid = 1'b1; s_axi_awaddr = addr; s_axi_awlen = len;
      s_axi_awsize = size; s_axi_awburst = burst; s_axi_awid = id;
      n = 0;
      while (s_axi_awready !== 1'b1 && n < 50) begin @(negedge ap_clk); n++; end
      if (n >= 50) begin errors++; $display("FAIL aw_timeout: awready low for %0d cycles, expected high within 50", n); end
      @(negedge ap_clk);
      s_axi_awvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         s_axi_wvalid = 1'b1; s_axi_wdata = wd[b]; s_axi_wstrb = ws[b]; s_axi_wlast = (b == last_at);
         n = 0;
         while (s_axi_wready !== 1'b1 && n < 50) begin @(negedge ap_clk); n++; end
         if (n >= 50) begin errors++; $display("FAIL w_timeout: wready low for %0d cycles, expected high within 50", n); end
         @(negedge ap_clk);
      end
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
      bwait = 0;
      while (s_axi_bvalid !== 1'b1 && bwait < 50) begin @(negedge ap_clk); bwait++; end
      if (bwait >= 50) begin errors++; $display("FAIL b_timeout: bvalid low for %0d cycles, expected high within 50", bwait); end
      bresp_s = s_axi_bresp; bid_s = s_axi_bid;
      @(negedge ap_clk);
      s_axi_bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [5:0] id, input bit toggle);
      int n, cyc;
      logic stalled, pl;
      logic [63:0] pd;
      nbeat = 0; stall_bad = 0; extra = 0;
      @(negedge ap_clk);
      s_axi_arvalid = 1'b1; s_axi_araddr = addr; s_axi_arlen = len;
      s_axi_arsize = size; s_axi_arburst = burst; s_axi_arid = id;
      n = 0;
      while (s_axi_arready !== 1'b1 && n < 50) begin @(negedge ap_clk); n++; end
      if (n >= 50) begin errors++; $display("FAIL ar_timeout: arready low for %0d cycles, expected high within 50", n); end
      @(negedge ap_clk);
      s_axi_arvalid = 1'b0;
      lat = 1;
      while (s_axi_rvalid !== 1'b1 && lat < 50) begin @(negedge ap_clk); lat++; end
      stalled = 1'b0; pd = '0; pl = 1'b0; cyc = 0;
      while (nbeat <= int'(len) && nbeat < 16 && cyc < 300) begin
         if (stalled && (s_axi_rvalid !== 1'b1 || s_axi_rdata !== pd || s_axi_rlast !== pl)) stall_bad++;
         s_axi_rready = toggle ? (cyc % 3 == 0) : 1'b1;
         if (s_axi_rvalid === 1'b1 && s_axi_rready) begin
            rd[nbeat] = s_axi_rdata; rl[nbeat] = s_axi_rlast; rr = s_axi_rresp; ri = s_axi_rid;
            nbeat++;
         end
         stalled = (s_axi_rvalid === 1'b1) && !s_axi_rready;
         pd = s_axi_rdata; pl = s_axi_rlast;
         @(negedge ap_clk);
         cyc++;
      end
      s_axi_rready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (s_axi_rvalid === 1'b1) extra++;
         @(negedge ap_clk);
      end
   endtask

   task automatic test_reset();
      #1 ap_rst_n = 1'b0;
      repeat (3) @(negedge ap_clk);
      checks++;
      if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast,
           s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid} !== 22'd0) begin
         errors++; $display("FAIL reset_ctrl: outputs %h, expected 0",
            {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast,
             s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid});
      end
      checks++;
      if (s_axi_rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", s_axi_rdata); end
      ap_rst_n = 1'b1;
      repeat (2) @(negedge ap_clk);
      checks++;
      if ({s_axi_awready, s_axi_arready} !== 2'b11) begin
         errors++; $display("FAIL reset_release_ready: aw/ar ready %b expected 11", {s_axi_awready, s_axi_arready});
      end
   endtask

   task automatic test_incr();
      for (int k = 0; k < 4; k++) begin wd[k] = 64'h1111_0000_0000_0000 + 64'(k); ws[k] = 8'hFF; end
      do_write(32'h100, 8'd3, 3'd3, 2'b01, 6'h05, 3);
      checks++;
      if (bresp_s !== 2'b00 || bid_s !== 6'h05) begin
         errors++; $display("FAIL incr_b: resp %b id %h, expected resp 00 id 05", bresp_s, bid_s);
      end
      checks++;
      if (bwait !== 0) begin errors++; $display("FAIL incr_b_timing: bvalid after %0d extra cycles, expected 0", bwait); end
      do_read(32'h100, 8'd3, 3'd3, 2'b01, 6'h2A, 1'b0);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL incr_latency: first rvalid %0d cycles after AR, expected 2", lat); end
      checks++;
      if (nbeat !== 4 || extra !== 0) begin errors++; $display("FAIL incr_beats: %0d beats %0d extra, expected 4 and 0", nbeat, extra); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rd[k] !== 64'h1111_0000_0000_0000 + 64'(k) || rl[k] !== (k == 3)) begin
            errors++; $display("FAIL incr_beat%0d: data %h last %b, expected %h last %b",
                               k, rd[k], rl[k], 64'h1111_0000_0000_0000 + 64'(k), (k == 3));
         end
      end
      checks++;
      if (ri !== 6'h2A || rr !== 2'b00) begin errors++; $display("FAIL incr_rid: id %h resp %b, expected 2a 00", ri, rr); end
   endtask

   task automatic test_strobe();
      wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
      do_write(32'h200, 8'd0, 3'd3, 2'b01, 6'h01, 0);
      wd[0] = 64'hAAAA_AAAA_AAAA_AAAA; ws[0] = 8'h0F;
      do_write(32'h200, 8'd0, 3'd3, 2'b01, 6'h02, 0);
      do_read(32'h200, 8'd0, 3'd3, 2'b01, 6'h03, 1'b0);
      checks++;
      if (rd[0] !== 64'hFFFF_FFFF_AAAA_AAAA) begin
         errors++; $display("FAIL strobe_merge: got %h expected ffffffffaaaaaaaa", rd[0]);
      end
   endtask

   task automatic test_backpressure();
      for (int k = 0; k < 8; k++) begin wd[k] = 64'hC0DE_0000_0000_0000 + 64'(k) * 64'h0101; ws[k] = 8'hFF; end
      do_write(32'h300, 8'd7, 3'd3, 2'b01, 6'h10, 7);
      do_read(32'h300, 8'd7, 3'd3, 2'b01, 6'h11, 1'b1);
      checks++;
      if (nbeat !== 8 || extra !== 0) begin errors++; $display("FAIL bp_beats: %0d beats %0d extra, expected 8 and 0", nbeat, extra); end
      checks++;
      if (stall_bad !== 0) begin errors++; $display("FAIL bp_stable: %0d unstable stall cycles, expected 0", stall_bad); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (rd[k] !== 64'hC0DE_0000_0000_0000 + 64'(k) * 64'h0101 || rl[k] !== (k == 7)) begin
            errors++; $display("FAIL bp_beat%0d: data %h last %b, expected %h last %b",
                               k, rd[k], rl[k], 64'hC0DE_0000_0000_0000 + 64'(k) * 64'h0101, (k == 7));
         end
      end
   endtask

   task automatic test_errors();
      wd[0] = 64'h0000_0000_0000_0BAD; ws[0] = 8'hFF;
      do_write(32'h100, 8'd0, 3'd2, 2'b01, 6'h06, 0);
      checks++;
      if (bresp_s !== 2'b10) begin errors++; $display("FAIL err_awsize_resp: got %b expected 10", bresp_s); end
      do_read(32'h100, 8'd0, 3'd3, 2'b01, 6'h06, 1'b0);
      checks++;
      if (rd[0] !== 64'h1111_0000_0000_0000) begin errors++; $display("FAIL err_awsize_mem: got %h expected 1111000000000000", rd[0]); end
      for (int k = 0; k < 4; k++) begin wd[k] = 64'h5; ws[k] = 8'hFF; end
      do_write(32'h400, 8'd3, 3'd3, 2'b01, 6'h07, 1);
      checks++;
      if (bresp_s !== 2'b10 || bid_s !== 6'h07) begin
         errors++; $display("FAIL err_wlast: resp %b id %h, expected 10 07", bresp_s, bid_s);
      end
      do_read(32'h100, 8'd0, 3'd2, 2'b01, 6'h08, 1'b0);
      checks++;
      if (rr !== 2'b10 || rd[0] !== 64'd0 || rl[0] !== 1'b1 || nbeat !== 1) begin
         errors++; $display("FAIL err_arsize: resp %b data %h last %b beats %0d, expected 10 0 1 1", rr, rd[0], rl[0], nbeat);
      end
   endtask

   task automatic test_alias_fixed();
      wd[0] = 64'hDEAD_BEEF_0000_0001; ws[0] = 8'hFF;
      do_write(32'h8000, 8'd0, 3'd3, 2'b01, 6'h09, 0);
      do_read(32'h0, 8'd0, 3'd3, 2'b01, 6'h09, 1'b0);
      checks++;
      if (rd[0] !== 64'hDEAD_BEEF_0000_0001) begin errors++; $display("FAIL alias: got %h expected deadbeef00000001", rd[0]); end
      for (int k = 0; k < 4; k++) begin wd[k] = 64'hF1F0_0000_0000_0000 + 64'(k); ws[k] = 8'hFF; end
      do_write(32'h40, 8'd3, 3'd3, 2'b00, 6'h0A, 3);
      do_read(32'h40, 8'd0, 3'd3, 2'b01, 6'h0A, 1'b0);
      checks++;
      if (rd[0] !== 64'hF1F0_0000_0000_0003) begin errors++; $display("FAIL fixed: got %h expected f1f0000000000003", rd[0]); end
   endtask

   task automatic test_reset_mid_read();
      int n, hs, stray;
      @(negedge ap_clk);
      s_axi_arvalid = 1'b1; s_axi_araddr = 32'h300; s_axi_arlen = 8'd7;
      s_axi_arsize = 3'd3; s_axi_arburst = 2'b01; s_axi_arid = 6'h20;
      n = 0;
      while (s_axi_arready !== 1'b1 && n < 50) begin @(negedge ap_clk); n++; end
      @(negedge ap_clk);
      s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
      hs = 0; n = 0;
      while (hs < 2 && n < 50) begin
         if (s_axi_rvalid === 1'b1) hs++;
         @(negedge ap_clk);
         n++;
      end
      checks++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 64'hC0DE_0000_0000_0202) begin
         errors++; $display("FAIL rst_pre_beat2: rvalid %b data %h, expected 1 c0de000000000202", s_axi_rvalid, s_axi_rdata);
      end
      #2 ap_rst_n = 1'b0;
      #1;
      checks++;
      if (s_axi_rvalid !== 1'b0 || s_axi_rdata !== 64'd0 || s_axi_arready !== 1'b0) begin
         errors++; $display("FAIL rst_async: rvalid %b rdata %h arready %b, expected 0 0 0", s_axi_rvalid, s_axi_rdata, s_axi_arready);
      end
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      stray = 0;
      repeat (2) begin if (s_axi_rvalid === 1'b1) stray++; @(negedge ap_clk); end
      checks++;
      if (s_axi_arready !== 1'b1) begin errors++; $display("FAIL rst_arready: got %b expected 1", s_axi_arready); end
      repeat (5) begin if (s_axi_rvalid === 1'b1) stray++; @(negedge ap_clk); end
      s_axi_rready = 1'b0;
      checks++;
      if (stray !== 0) begin errors++; $display("FAIL rst_stale: %0d stale rvalid cycles, expected 0", stray); end
      do_read(32'h200, 8'd0, 3'd3, 2'b01, 6'h21, 1'b0);
      checks++;
      if (rd[0] !== 64'hFFFF_FFFF_AAAA_AAAA || nbeat !== 1) begin
         errors++; $display("FAIL rst_mem_kept: got %h beats %0d, expected ffffffffaaaaaaaa 1", rd[0], nbeat);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_incr();
      test_strobe();
      test_backpressure();
      test_errors();
      test_alias_fixed();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
